// File: rtl/signed_seq_divider_if.sv
// ============================================================================
// Module      : signed_seq_divider_if
// Description : Start/busy/done handshake and operand/result bus for the
//               sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signed_seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             divByZero;

    modport master (
        output start, a, b,
        input  quotient, remainder, busy, done, divByZero
    );

    modport slave (
        input  start, a, b,
        output quotient, remainder, busy, done, divByZero
    );
endinterface

`default_nettype wire

// File: rtl/signed_seq_divider.sv
// ============================================================================
// Module      : signed_seq_divider
// Description : Signed restoring divider, one quotient bit per clock, fixed
//               WIDTH+1 cycle latency with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_seq_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    signed_seq_divider_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             start_ok;
    logic             last_iter;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic             busy;
    logic             done;

    assign start_ok  = bus.start && (state_q != S_CALC);
    assign last_iter = (state_q == S_CALC) && (cnt_q == CNT_W'(WIDTH));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = start_ok ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // The correction cycle is the final CALC cycle, so busy covers it too.
    always_comb begin
        busy = (state_q == S_CALC);
        done = (state_q == S_DONE);
    end

    // ---------------- datapath ----------------
    always_comb begin
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        a_d           = a_q;
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        b_zero_d      = b_zero_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        // Partial remainder stays below |b|, so the shifted value needs one
        // extra bit and a true difference always fits back in WIDTH bits.
        shifted = {rem_q, dvd_q[WIDTH-1]};
        fits    = (shifted >= {1'b0, dvs_q});
        diff    = shifted[WIDTH-1:0] - dvs_q;

        if (start_ok) begin
            a_d      = bus.a;
            sign_a_d = bus.a[WIDTH-1];
            sign_b_d = bus.b[WIDTH-1];
            dvd_d    = bus.a[WIDTH-1] ? -bus.a : bus.a;
            dvs_d    = bus.b[WIDTH-1] ? -bus.b : bus.b;
            b_zero_d = (bus.b == '0);
            rem_d    = '0;
            cnt_d    = '0;
        end else if (state_q == S_CALC) begin
            if (!last_iter) begin
                rem_d = fits ? diff : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], fits};
                cnt_d = cnt_q + 1'b1;
            end else if (b_zero_q) begin
                quotient_d    = '1;
                remainder_d   = a_q;
                div_by_zero_d = 1'b1;
            end else begin
                // Most-negative / -1 wraps back to most-negative, unflagged.
                quotient_d    = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
                remainder_d   = sign_a_q ? -rem_q : rem_q;
                div_by_zero_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            a_q           <= '0;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            b_zero_q      <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            a_q           <= a_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            b_zero_q      <= b_zero_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.divByZero = div_by_zero_q;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule

`default_nettype wire

// File: doc/signed_seq_divider.md
# signed_seq_divider

Sequential signed integer divider producing a quotient and remainder by restoring division, one quotient bit per clock. It is the inverse-operation companion to the radix-4 Booth multiplier in the multipliers collection, and uses the same clocking, reset and operand-width conventions, so that multiply and divide can share a datapath wrapper and testbench style. It has a fixed, data-independent latency, with a start/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits (two's complement); must be ≥ 2
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  signed dividend; sampled with start
- b  input  WIDTH  signed divisor; sampled with start
- quotient  output  WIDTH  signed quotient, registered
- remainder  output  WIDTH  signed remainder, registered
- busy  output  1  operation in progress; start ignored while high
- done  output  1  one-cycle pulse: results valid and updated this cycle
- divByZero  output  1  set with done when b was 0; held with the results

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE with start=1 at an edge:
  - latch sign(a), sign(b), |a| and |b| as WIDTH-bit unsigned values (|−2^(WIDTH−1)| = 2^(WIDTH−1), which fits unsigned);
  - clear the partial remainder (WIDTH+1 bits) and the iteration counter;
  - go to CALC.
- IDLE/DONE with start=0 at an edge: DONE goes to IDLE; IDLE stays in IDLE.
- CALC, each edge (WIDTH iterations, MSB first):
  - shift the partial remainder left, bringing in the next dividend bit;
  - trial-subtract |b|; if non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
- After iteration WIDTH, at the next edge:
  - apply sign correction, register quotient/remainder/divByZero, go to DONE.
- Sign rules:
  - quotient truncates toward zero; it is negated when sign(a) ≠ sign(b);
  - remainder takes the sign of the dividend, and |remainder| < |b|.
- Divide by zero (b = 0):
  - same latency, iterations still run;
  - quotient = all ones (−1), remainder = a unmodified, divByZero = 1.
- Overflow (a = −2^(WIDTH−1), b = −1): quotient = −2^(WIDTH−1), remainder = 0, divByZero = 0. No flag is raised.
- Outputs hold their last results until the next completion. They do not change during CALC.

## Timing
- Reset (async, any state, mid-operation included):
  - state → IDLE;
  - quotient = 0, remainder = 0, busy = 0, done = 0, divByZero = 0;
  - any in-flight operation is abandoned and produces no done.
- Start accepted at edge E0 (busy=0, start=1):
  - busy = 1 from after E0 through edge E0+WIDTH+1;
  - at edge E0+WIDTH+1, results register, busy → 0 and done → 1;
  - done → 0 at edge E0+WIDTH+2.
- Latency is WIDTH+1 cycles (33 for WIDTH=32), independent of the operand values.
- Back-to-back: start held high during the done cycle is accepted at edge E0+WIDTH+2. This gives throughput of one result per WIDTH+2 cycles.
- start while busy=1: ignored, and a/b are not resampled. a/b may change freely after E0.
- done is never high while busy is high. busy = 1 ⇔ state CALC or the final correction cycle.
- Release of reset followed immediately by start: accepted at the first edge with reset low.

## Test plan
- Reset, then a=100, b=7, start pulse → after exactly 33 cycles: done=1 for one cycle, quotient=14, remainder=2, divByZero=0; busy high for exactly 33 cycles.
- Signs:
  - (−100, 7) → (−14, −2);
  - (100, −7) → (−14, 2);
  - (−12, −4) → (3, 0);
  - (5, −7) → (0, 5).
- Divide by zero: a=5, b=0 → quotient=−1, remainder=5, divByZero=1; then a=9, b=3 → quotient=3, remainder=0, divByZero=0.
- Boundaries: (−2147483648, −1) → quotient=−2147483648, remainder=0; (−2147483648, 2147483647) → quotient=−1, remainder=−1.
- Handshake:
  - start re-pulsed with different a/b at cycle 10 of an operation → ignored, and the first result is unchanged;
  - start held high during the done cycle → second result arrives 34 cycles after the first.
- Reset asserted at cycle 15 of an operation → all outputs 0 immediately and no done follows; a new start after reset produces correct results.
